instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues reads to instruction memory and
// buffers the returned words in a DEPTH-entry prefetch FIFO for decode.
// Latency: a fetch issued in cycle N is visible to decode in cycle N+2.
// Backpressure: stops issuing when buffered + in-flight words would exceed DEPTH.
// Ports:
//   clk, rst                     clock, async active-high reset
//   rd_en_im, im_address         read request to instruction memory
//   im_instruction               memory read data (one cycle after request)
//   instr_valid/instr_ready      decode handshake; instr/instr_pc = head entry
//   redirect_en, redirect_addr   branch/jump: flush buffer, load new PC
//   halt                         suppress new fetches while high
module instruction_fetch_unit #(
  parameter int                    WORD_SIZE  = 19,
  parameter int                    ADDR_WIDTH = 19,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  rd_en_im,
  output logic [ADDR_WIDTH-1:0] im_address,
  input  logic [WORD_SIZE-1:0]  im_instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [WORD_SIZE-1:0]  instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic [WORD_SIZE-1:0]  r_buf_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] r_buf_pc    [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_hs;
  logic                  w_pop;
  logic                  w_push;
  logic [CNT_W:0]        w_level;

  assign instr_valid = (r_count != '0);
  assign instr       = r_buf_instr[r_head];
  assign instr_pc    = r_buf_pc[r_head];
  assign im_address  = r_pc;

  // The raw handshake frees a slot for issue purposes; a redirect discards
  // the whole buffer anyway, so the effective pop is masked by it.
  assign w_hs   = instr_valid && instr_ready;
  assign w_pop  = w_hs && !redirect_en;
  assign w_push = r_inflight && !redirect_en;

  // Slots committed next cycle: buffered + in flight - leaving now.
  // Never negative because a handshake implies r_count >= 1.
  assign w_level = {1'b0, r_count}
                 + {{CNT_W{1'b0}}, r_inflight}
                 - {{CNT_W{1'b0}}, w_hs};

  // Gated by rst so the request is withdrawn the moment reset asserts.
  assign rd_en_im = !rst && !halt && !redirect_en
                    && (w_level < (CNT_W+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_req_pc   <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else if (redirect_en) begin
      // Flush: the response of any outstanding request is dropped by
      // clearing r_inflight, so it is never pushed.
      r_pc       <= redirect_addr;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= rd_en_im;
      if (rd_en_im) begin
        r_pc     <= r_pc + ADDR_WIDTH'(1);
        r_req_pc <= r_pc;
      end
      if (w_push) begin
        r_buf_instr[r_tail] <= im_instruction;
        r_buf_pc[r_tail]    <= r_req_pc;
        r_tail              <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus random
// handshake/halt/redirect traffic, checked against a queue-based model.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        rd_en_im;
  logic [18:0] im_address;
  logic [18:0] im_instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [18:0] instr;
  logic [18:0] instr_pc;
  logic        redirect_en;
  logic [18:0] redirect_addr;
  logic        halt;

  // Second instance parked near the top of the address space.
  logic        w_rd;
  logic [18:0] w_addr;
  logic [18:0] w_im;
  logic        w_valid;
  logic        w_ready;
  logic [18:0] w_instr;
  logic [18:0] w_ipc;
  logic        w_redir;
  logic [18:0] w_raddr;
  logic        w_halt;

  int n_checks = 0;
  int n_errors = 0;

  // Sampled outputs of the most recent cycle.
  logic        s_rd, s_valid;
  logic [18:0] s_addr, s_instr, s_pc, s_waddr;

  // Reference model: next PC to fetch, in-flight request, buffered PCs.
  logic [18:0] m_pc;
  bit          m_inf;
  logic [18:0] m_inf_pc;
  logic [18:0] m_q[$];

  instruction_fetch_unit #(
    .WORD_SIZE(19), .ADDR_WIDTH(19), .RESET_PC(19'h00000), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rd_en_im(rd_en_im), .im_address(im_address),
    .im_instruction(im_instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .halt(halt)
  );

  instruction_fetch_unit #(
    .WORD_SIZE(19), .ADDR_WIDTH(19), .RESET_PC(19'h7FFFE), .DEPTH(DEPTH)
  ) u_wrap (
    .clk(clk), .rst(rst), .rd_en_im(w_rd), .im_address(w_addr),
    .im_instruction(w_im), .instr_valid(w_valid),
    .instr_ready(w_ready), .instr(w_instr), .instr_pc(w_ipc),
    .redirect_en(w_redir), .redirect_addr(w_raddr), .halt(w_halt)
  );

  function automatic logic [18:0] memf(input logic [18:0] a);
    case (a)
      19'd0:   return 19'h01234;
      19'd1:   return 19'h2ABCD;
      19'd2:   return 19'h05678;
      19'd3:   return 19'h79EFF;
      default: return {a[9:0], a[18:10]} ^ 19'h2A5A5;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en_im) im_instruction <= memf(im_address);
    if (w_rd)     w_im           <= memf(w_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, check at the falling
  // edge, advance the model to the next rising edge.
  task automatic cycle(input bit rdy, input bit hlt, input bit redir,
                       input logic [18:0] raddr);
    bit ev, hs, erd;
    int lvl;
    instr_ready   = rdy;
    halt          = hlt;
    redirect_en   = redir;
    redirect_addr = raddr;
    @(negedge clk);
    s_rd = rd_en_im; s_valid = instr_valid; s_addr = im_address;
    s_instr = instr; s_pc = instr_pc; s_waddr = w_addr;
    ev  = (m_q.size() != 0);
    hs  = ev && rdy;
    lvl = m_q.size() + int'(m_inf) - int'(hs);
    erd = !hlt && !redir && (lvl < DEPTH);
    chk("rd_en_im", 32'(rd_en_im), 32'(erd));
    chk("im_address", 32'(im_address), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    if (ev) begin
      chk("instr_pc", 32'(instr_pc), 32'(m_q[0]));
      chk("instr", 32'(instr), 32'(memf(m_q[0])));
    end
    if (redir) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = raddr;
    end else begin
      if (hs) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      m_inf    = erd;
      m_inf_pc = m_pc;
      if (erd) m_pc = m_pc + 19'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; checks take effect with no clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_addr", 32'(im_address), 32'd0);
    chk("rst_rd", 32'(rd_en_im), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    m_q.delete();
    m_inf = 1'b0;
    m_pc  = 19'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [18:0] tbl [4];
    tbl[0] = 19'h01234; tbl[1] = 19'h2ABCD; tbl[2] = 19'h05678; tbl[3] = 19'h79EFF;
    rst = 1'b1; instr_ready = 1'b0; halt = 1'b0; redirect_en = 1'b0;
    redirect_addr = '0;
    w_ready = 1'b1; w_redir = 1'b0; w_raddr = '0; w_halt = 1'b0;
    m_q.delete(); m_inf = 1'b0; m_pc = '0; m_inf_pc = '0;
    @(posedge clk);
    #1;
    async_reset();

    // Streaming from reset, plus the wrap instance's address sequence.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 19'd0);
      if (i < 4) chk("stream_addr", 32'(s_addr), 32'(i));
      if (i == 0) chk("wrap_addr0", 32'(s_waddr), 32'h7FFFE);
      if (i == 1) chk("wrap_addr1", 32'(s_waddr), 32'h7FFFF);
      if (i == 2) chk("wrap_addr2", 32'(s_waddr), 32'h00000);
      if (i == 1) chk("first_valid_early", 32'(s_valid), 32'd0);
      if (i >= 2) begin
        chk("stream_instr", 32'(s_instr), 32'(tbl[i-2]));
        chk("stream_pc", 32'(s_pc), 32'(i-2));
      end
    end

    // Backpressure from reset: buffer fills, head holds, fetch stops.
    async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 19'd0);
    chk("bp_rd", 32'(s_rd), 32'd0);
    chk("bp_valid", 32'(s_valid), 32'd1);
    chk("bp_instr", 32'(s_instr), 32'h01234);
    chk("bp_pc", 32'(s_pc), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 19'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 19'd0);
    chk("bp_full_again", 32'(s_rd), 32'd0);
    async_reset();

    // Redirect while the address-2 fetch is outstanding.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 19'd0);
    cycle(1'b1, 1'b0, 1'b1, 19'h00040);
    chk("redir_rd", 32'(s_rd), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 19'd0);
    chk("redir_addr", 32'(s_addr), 32'h00040);
    chk("redir_issue", 32'(s_rd), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 19'd0);
    chk("redir_flushed", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 19'd0);
    chk("redir_pc", 32'(s_pc), 32'h00040);
    chk("redir_valid", 32'(s_valid), 32'd1);

    // Halt for 5 cycles: in-flight word delivered, buffer drains.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 19'd0);
      chk("halt_rd", 32'(s_rd), 32'd0);
    end
    chk("halt_drained", 32'(s_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 19'd0);
    chk("halt_resume_rd", 32'(s_rd), 32'd1);
    chk("halt_resume_addr", 32'(s_addr), 32'h00043);

    // Redirect while halted: PC moves, nothing issues until halt drops.
    cycle(1'b1, 1'b1, 1'b1, 19'h7FFFF);
    cycle(1'b1, 1'b1, 1'b0, 19'd0);
    chk("halt_redir_rd", 32'(s_rd), 32'd0);
    chk("halt_redir_addr", 32'(s_addr), 32'h7FFFF);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, h, d;
      logic [18:0] a;
      r = ($urandom_range(3) != 0);
      h = ($urandom_range(9) == 0);
      d = ($urandom_range(15) == 0);
      a = ($urandom_range(3) == 0) ? 19'h7FFFE : 19'($urandom);
      cycle(r, h, d, a);
    end

    // Reset with the buffer full, then a short run.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 19'd0);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 19'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
